// File: rtl/spi_txn_arbiter.sv
// ---------------------------------------------------------------------------
// spi_txn_arbiter: round-robin sharing of one SPI master among NUM_REQ
// requesters, with inter-transaction gap and a done watchdog.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module spi_txn_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int GAP_CYC     = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [16*NUM_REQ-1:0] req_cmd,
  output logic [NUM_REQ-1:0]    ack,
  output logic [15:0]           resp,
  output logic                  timeout_err,
  output logic                  busy,
  output logic                  wrt,
  output logic [15:0]           cmd,
  input  logic                  done,
  input  logic [15:0]           rd_data
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int GAP_W = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;
  localparam int WD_W  = $clog2(TIMEOUT_CYC);

  localparam logic [IDX_W:0]     NUM_REQ_W = (IDX_W + 1)'(NUM_REQ);
  localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(NUM_REQ - 1);
  localparam logic [GAP_W-1:0]   GAP_LOAD  = GAP_W'(GAP_CYC);
  localparam logic [WD_W-1:0]    WD_LAST   = WD_W'(TIMEOUT_CYC - 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0  = NUM_REQ'(1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2,
    GAP       = 2'd3
  } state_t;

  state_t             state;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   gnt_idx;
  logic [GAP_W-1:0]   gap_cnt;
  logic [WD_W-1:0]    wd_cnt;

  logic [2*NUM_REQ-1:0] req_dbl;
  logic [NUM_REQ-1:0]   req_rot;
  logic [IDX_W-1:0]     sel_off;
  logic [IDX_W:0]       sel_sum;
  logic [IDX_W-1:0]     sel_idx;
  logic [15:0]          sel_cmd;
  logic                 sel_valid;
  logic [IDX_W-1:0]     next_ptr;

  // Rotate requests so bit 0 is rr_ptr, take the lowest set bit, un-rotate.
  always_comb begin
    req_dbl   = {req, req};
    req_rot   = req_dbl[{1'b0, rr_ptr} +: NUM_REQ];
    sel_valid = |req;
    sel_off   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_rot[k]) sel_off = IDX_W'(k);
    end
    sel_sum = {1'b0, rr_ptr} + {1'b0, sel_off};
    if (sel_sum >= NUM_REQ_W) sel_sum = sel_sum - NUM_REQ_W;
    sel_idx = sel_sum[IDX_W-1:0];
    sel_cmd = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (sel_idx == IDX_W'(i)) sel_cmd = req_cmd[16*i +: 16];
    end
    next_ptr = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      gnt_idx     <= '0;
      gap_cnt     <= '0;
      wd_cnt      <= '0;
      ack         <= '0;
      resp        <= '0;
      timeout_err <= 1'b0;
      busy        <= 1'b0;
      wrt         <= 1'b0;
      cmd         <= '0;
    end else begin
      wrt <= 1'b0;
      ack <= '0;
      case (state)
        IDLE: begin
          if (sel_valid) begin
            gnt_idx <= sel_idx;
            cmd     <= sel_cmd;
            wrt     <= 1'b1;
            busy    <= 1'b1;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          wd_cnt <= '0;
          state  <= WAIT_DONE;
        end
        WAIT_DONE: begin
          // done takes priority over a watchdog expiry in the same cycle
          if (done) begin
            resp    <= rd_data;
            ack     <= ONE_HOT0 << gnt_idx;
            rr_ptr  <= next_ptr;
            gap_cnt <= GAP_LOAD;
            state   <= GAP;
          end else if (wd_cnt == WD_LAST) begin
            resp        <= 16'h0000;
            ack         <= ONE_HOT0 << gnt_idx;
            timeout_err <= 1'b1;
            rr_ptr      <= next_ptr;
            gap_cnt     <= GAP_LOAD;
            state       <= GAP;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        GAP: begin
          if (gap_cnt == '0) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_spi_txn_arbiter.sv
// ---------------------------------------------------------------------------
// tb_spi_txn_arbiter: directed scoreboard bench for spi_txn_arbiter with a
// scripted SPI master model.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_spi_txn_arbiter;

  localparam int NUM_REQ     = 4;
  localparam int GAP_CYC     = 4;
  localparam int TIMEOUT_CYC = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req;
  logic [63:0] req_cmd;
  logic [3:0]  ack;
  logic [15:0] resp;
  logic        timeout_err;
  logic        busy;
  logic        wrt;
  logic [15:0] cmd;
  logic        done;
  logic [15:0] rd_data;

  always #5 clk = ~clk;

  spi_txn_arbiter #(
    .NUM_REQ(NUM_REQ),
    .GAP_CYC(GAP_CYC),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req(req),
    .req_cmd(req_cmd),
    .ack(ack),
    .resp(resp),
    .timeout_err(timeout_err),
    .busy(busy),
    .wrt(wrt),
    .cmd(cmd),
    .done(done),
    .rd_data(rd_data)
  );

  typedef struct {
    logic [3:0]  ack;
    logic [15:0] resp;
    logic        terr;
  } ack_t;

  typedef struct {
    int          lat;
    logic [15:0] data;
  } mst_t;

  ack_t        exp_ack[$];
  logic [15:0] exp_wrt[$];
  mst_t        mst_q[$];

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  int prev_wrt = -1;
  bit chk_spacing = 1'b0;
  int stray_req = 0;
  int stray_ack = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Master model: each wrt pops one script entry; lat=0 means never answer.
  initial begin
    int m_cnt;
    logic [15:0] m_data;
    m_cnt   = 0;
    m_data  = '0;
    done    = 1'b0;
    rd_data = 16'hFFFF;
    forever begin
      @(posedge clk);
      #1;
      done    = 1'b0;
      rd_data = 16'hFFFF;
      if (!rst_n) begin
        m_cnt = 0;
      end else if (wrt) begin
        if (mst_q.size() > 0) begin
          mst_t m;
          m      = mst_q.pop_front();
          m_cnt  = m.lat;
          m_data = m.data;
        end else begin
          m_cnt = 0;
        end
      end else if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          done    = 1'b1;
          rd_data = m_data;
        end
      end else if (stray_req != stray_ack) begin
        stray_ack = stray_req;
        done      = 1'b1;
        rd_data   = 16'hDEAD;
      end
    end
  end

  // Monitor: compares every wrt and every ack against the queued expectations.
  always @(negedge clk) begin
    if (rst_n) begin
      if (wrt) begin
        check("wrt_without_ack", {28'd0, ack}, 32'd0);
        if (exp_wrt.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL unexpected_wrt: cmd=%h expected no wrt", cmd);
        end else begin
          check("wrt_cmd", {16'd0, cmd}, {16'd0, exp_wrt.pop_front()});
        end
        if (chk_spacing && prev_wrt >= 0)
          check("wrt_spacing", cyc - prev_wrt, 32'd9);
        prev_wrt <= cyc;
      end
      if (ack != 4'b0000) begin
        if (exp_ack.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL unexpected_ack: ack=%b resp=%h expected no ack", ack, resp);
        end else begin
          ack_t e;
          e = exp_ack.pop_front();
          check("ack_vec", {28'd0, ack}, {28'd0, e.ack});
          check("ack_resp", {16'd0, resp}, {16'd0, e.resp});
          check("ack_timeout_err", {31'd0, timeout_err}, {31'd0, e.terr});
        end
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 4'b0000;
    repeat (2) @(negedge clk);
    rst_n    = 1'b1;
    prev_wrt = -1;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while (1) begin
      @(negedge clk);
      req = req & ~ack;
      if (req == 4'b0000 && !busy && exp_ack.size() == 0) break;
      n++;
      if (n > budget) begin
        n_chk++;
        n_err++;
        $display("FAIL %s_stall: busy=%b req=%b pending_acks=%0d, expected idle", name, busy, req,
                 exp_ack.size());
        exp_ack.delete();
        exp_wrt.delete();
        mst_q.delete();
        req = 4'b0000;
        break;
      end
    end
  endtask

  initial begin
    int n;
    logic [15:0] t2_cmd [4];
    logic [15:0] t2_dat [4];
    t2_cmd = '{16'h1001, 16'h2002, 16'h3003, 16'h4004};
    t2_dat = '{16'hAAA0, 16'hBBB1, 16'hCCC2, 16'hDDD3};
    req     = 4'b0000;
    req_cmd = '0;

    // Reset state
    do_reset();
    @(negedge clk);
    check("rst_ack", {28'd0, ack}, 32'd0);
    check("rst_resp", {16'd0, resp}, 32'd0);
    check("rst_timeout_err", {31'd0, timeout_err}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_wrt", {31'd0, wrt}, 32'd0);
    check("rst_cmd", {16'd0, cmd}, 32'd0);

    // Single request: latency and gap timing
    req_cmd[31:16] = 16'hA5C3;
    mst_q.push_back('{3, 16'h1234});
    exp_wrt.push_back(16'hA5C3);
    exp_ack.push_back('{4'b0010, 16'h1234, 1'b0});
    req = 4'b0010;
    @(posedge clk);
    #1;
    check("t1_wrt_latency", {31'd0, wrt}, 32'd1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ack == 4'b0000 && n < 50);
    check("t1_ack_seen", {28'd0, ack}, 32'h2);
    req = 4'b0000;
    repeat (GAP_CYC) @(negedge clk);
    check("t1_busy_in_gap", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check("t1_busy_released", {31'd0, busy}, 32'd0);

    // All four requesting from reset: order 0,1,2,3 with fixed spacing
    do_reset();
    for (int i = 0; i < 4; i++) begin
      req_cmd[16*i +: 16] = t2_cmd[i];
      mst_q.push_back('{2, t2_dat[i]});
      exp_wrt.push_back(t2_cmd[i]);
      exp_ack.push_back('{4'(1 << i), t2_dat[i], 1'b0});
    end
    chk_spacing = 1'b1;
    req = 4'b1111;
    wait_idle("t2", 200);
    chk_spacing = 1'b0;

    // Round-robin pointer: after req0, req2 wins over req0
    do_reset();
    req_cmd[15:0] = 16'h0A0A;
    mst_q.push_back('{1, 16'h5001});
    exp_wrt.push_back(16'h0A0A);
    exp_ack.push_back('{4'b0001, 16'h5001, 1'b0});
    req = 4'b0001;
    wait_idle("t3a", 100);
    req_cmd[47:32] = 16'h0C0C;
    mst_q.push_back('{1, 16'h5002});
    mst_q.push_back('{1, 16'h5003});
    exp_wrt.push_back(16'h0C0C);
    exp_wrt.push_back(16'h0A0A);
    exp_ack.push_back('{4'b0100, 16'h5002, 1'b0});
    exp_ack.push_back('{4'b0001, 16'h5003, 1'b0});
    req = 4'b0101;
    wait_idle("t3b", 100);

    // Watchdog timeout, then sticky timeout_err across a good transaction
    req_cmd[63:48] = 16'h0F0F;
    mst_q.push_back('{0, 16'h0000});
    exp_wrt.push_back(16'h0F0F);
    exp_ack.push_back('{4'b1000, 16'h0000, 1'b1});
    req = 4'b1000;
    wait_idle("t4a", TIMEOUT_CYC + 100);
    check("t4_terr_set", {31'd0, timeout_err}, 32'd1);
    req_cmd[31:16] = 16'h0B0B;
    mst_q.push_back('{2, 16'h6001});
    exp_wrt.push_back(16'h0B0B);
    exp_ack.push_back('{4'b0010, 16'h6001, 1'b1});
    req = 4'b0010;
    wait_idle("t4b", 100);
    check("t4_terr_sticky", {31'd0, timeout_err}, 32'd1);

    // done in the same cycle as watchdog expiry: normal completion
    do_reset();
    check("t5_terr_cleared", {31'd0, timeout_err}, 32'd0);
    req_cmd[15:0] = 16'h0D0D;
    mst_q.push_back('{TIMEOUT_CYC, 16'hBEEF});
    exp_wrt.push_back(16'h0D0D);
    exp_ack.push_back('{4'b0001, 16'hBEEF, 1'b0});
    req = 4'b0001;
    wait_idle("t5", TIMEOUT_CYC + 100);
    check("t5_terr_clear", {31'd0, timeout_err}, 32'd0);

    // Stray done while idle
    stray_req++;
    repeat (4) begin
      @(negedge clk);
      check("stray_ack", {28'd0, ack}, 32'd0);
      check("stray_busy", {31'd0, busy}, 32'd0);
    end

    // Reset while waiting for done, then restart from rr_ptr=0
    req_cmd[47:32] = 16'h0E02;
    req_cmd[63:48] = 16'h0E03;
    mst_q.push_back('{0, 16'h0000});
    exp_wrt.push_back(16'h0E02);
    req = 4'b1100;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!wrt && n < 20);
    check("t6_wrt_seen", {31'd0, wrt}, 32'd1);
    repeat (5) @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("t6_rst_ack", {28'd0, ack}, 32'd0);
    check("t6_rst_resp", {16'd0, resp}, 32'd0);
    check("t6_rst_terr", {31'd0, timeout_err}, 32'd0);
    check("t6_rst_busy", {31'd0, busy}, 32'd0);
    check("t6_rst_wrt", {31'd0, wrt}, 32'd0);
    check("t6_rst_cmd", {16'd0, cmd}, 32'd0);
    mst_q.delete();
    mst_q.push_back('{2, 16'h2222});
    mst_q.push_back('{2, 16'h3333});
    exp_wrt.push_back(16'h0E02);
    exp_wrt.push_back(16'h0E03);
    exp_ack.push_back('{4'b0100, 16'h2222, 1'b0});
    exp_ack.push_back('{4'b1000, 16'h3333, 1'b0});
    @(negedge clk);
    rst_n    = 1'b1;
    prev_wrt = -1;
    wait_idle("t6", 100);

    check("queues_drained", exp_ack.size() + exp_wrt.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
